// File: rtl/gf2m_alu.sv
// Arithmetic unit for GF(2^163) with f(x)=x^163+x^7+x^6+x^3+1.
// ADD/SQR/PASS complete in one cycle; MUL is a digit-serial MSB-first multiply.
module gf2m_alu #(
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [162:0]   alu_x,
  input  logic [162:0]   alu_z,
  output logic [162:0]   result,
  output logic           busy,
  output logic           done,
  output logic           dbg_state
);

  localparam int M  = 163;
  localparam int N  = (M + DIGIT - 1) / DIGIT;
  localparam int NB = N * DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SQR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // Low-order terms of f; x^163 folds onto these.
  localparam logic [M-1:0] POLY_LOW = {{(M-8){1'b0}}, 8'hC9};

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  // Handshake: start is sampled only in IDLE; done pulses one cycle with result
  // valid in that same cycle; busy is high while a MUL is iterating.

  state_t          state_q, state_d;
  logic [M-1:0]    a_q;
  logic [NB-1:0]   b_q;
  logic [NB-1:0]   b_ext;
  logic [M-1:0]    acc_q;
  logic [M-1:0]    acc_next;
  logic [CW-1:0]   cnt_q;
  logic [M-1:0]    result_q;
  logic            done_q;
  logic [DIGIT-1:0] digit;
  logic [M-1:0]    alu_result;

  function automatic logic [M-1:0] mul_step(input logic [M-1:0] acc,
                                            input logic [M-1:0] a,
                                            input logic [DIGIT-1:0] dg);
    logic [M+DIGIT-1:0] w;
    logic [M-1:0]       r;
    w = {acc, {DIGIT{1'b0}}};
    for (int j = 0; j < DIGIT; j++) begin
      if (dg[j]) w = w ^ ({{DIGIT{1'b0}}, a} << j);
    end
    r = w[M-1:0];
    // DIGIT<=16 keeps every folded term below x^163, so one pass is enough.
    for (int k = 0; k < DIGIT; k++) begin
      if (w[M+k]) r = r ^ (POLY_LOW << k);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] x);
    logic [2*M-2:0] w;
    w = '0;
    for (int i = 0; i < M; i++) w[2*i] = x[i];
    for (int i = 2*M-2; i >= M; i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w[i-M +: 8] = w[i-M +: 8] ^ 8'hC9;
      end
    end
    return w[M-1:0];
  endfunction

  always_comb begin
    b_ext        = '0;
    b_ext[M-1:0] = alu_z;
    digit        = b_q[cnt_q*DIGIT +: DIGIT];
    acc_next     = mul_step(acc_q, a_q, digit);
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = alu_x ^ alu_z;
      OP_SQR:  alu_result = gf_sqr(alu_x);
      OP_PASS: alu_result = alu_x;
      default: alu_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && op == OP_MUL) state_d = S_MUL;
      S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_MUL);
    done      = done_q;
    result    = result_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              a_q   <= alu_x;
              b_q   <= b_ext;
              acc_q <= '0;
              cnt_q <= CW'(N - 1);
            end else begin
              result_q <= alu_result;
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_q <= acc_next;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
